// File: rtl/display_text_scroller.sv
// Producer for the 8-digit seven-segment display: holds a message buffer and
// presents it either left-aligned or scrolling right-to-left, one step per tick.
module display_text_scroller #(
    parameter int          DEPTH       = 16,
    parameter int          TICK_CYCLES = 50_000_000,
    parameter logic [7:0]  BLANK       = 8'hFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [3:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic [4:0] msg_len,
    input  logic       mode,
    input  logic       loop,
    input  logic       start,
    input  logic       stop,
    output logic [7:0] data7,
    output logic [7:0] data6,
    output logic [7:0] data5,
    output logic [7:0] data4,
    output logic [7:0] data3,
    output logic [7:0] data2,
    output logic [7:0] data1,
    output logic [7:0] data0,
    output logic       busy,
    output logic       done,
    output logic [1:0] state_dbg
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int LEN_W  = $clog2(DEPTH + 1);
    localparam int OFF_W  = $clog2(DEPTH + 16);
    localparam int TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STATIC = 2'd1,
        S_SCROLL = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [7:0]          msg_q [DEPTH];
    logic [7:0]          msg_d [DEPTH];
    logic [LEN_W-1:0]    len_q, len_d;
    logic                loop_q, loop_d;
    logic [OFF_W-1:0]    offset_q, offset_d;
    logic [TICK_W-1:0]   tick_q, tick_d;
    logic                done_q, done_d;
    logic [7:0]          data_q [8];
    logic [7:0]          data_d [8];
    logic                tick;

    assign tick = (tick_q == TICK_W'(TICK_CYCLES - 1));

    // Buffer is only writable while idle so a running display never tears.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            msg_d[i] = msg_q[i];
        end
        if (state_q == S_IDLE && wr_en) begin
            msg_d[wr_addr] = wr_data;
        end
    end

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        loop_d   = loop_q;
        offset_d = offset_q;
        tick_d   = tick_q;
        done_d   = 1'b0;
        if (stop) begin
            state_d  = S_IDLE;
            offset_d = '0;
            tick_d   = '0;
        end else if (start) begin
            if (int'(msg_len) > DEPTH) len_d = LEN_W'(DEPTH);
            else                       len_d = LEN_W'(msg_len);
            loop_d   = loop;
            offset_d = '0;
            tick_d   = '0;
            state_d  = mode ? S_SCROLL : S_STATIC;
        end else if (state_q == S_SCROLL) begin
            if (tick) begin
                tick_d = '0;
                // offset == len+8 means the last character has left at the left edge.
                if (offset_q == OFF_W'(len_q) + OFF_W'(8)) begin
                    done_d   = 1'b1;
                    offset_d = '0;
                    if (!loop_q) state_d = S_IDLE;
                end else begin
                    offset_d = offset_q + OFF_W'(1);
                end
            end else begin
                tick_d = tick_q + TICK_W'(1);
            end
        end
    end

    // Window is built from next-state values so the display updates with the state.
    always_comb begin
        for (int k = 0; k < 8; k++) begin
            data_d[7-k] = BLANK;
            if (state_d == S_STATIC) begin
                if (k < int'(len_d)) data_d[7-k] = msg_q[ADDR_W'(k)];
            end else if (state_d == S_SCROLL) begin
                if ((int'(offset_d) + k >= 8) && (int'(offset_d) + k < int'(len_d) + 8)) begin
                    data_d[7-k] = msg_q[ADDR_W'(int'(offset_d) + k - 8)];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            len_q    <= '0;
            loop_q   <= 1'b0;
            offset_q <= '0;
            tick_q   <= '0;
            done_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) msg_q[i] <= BLANK;
            for (int k = 0; k < 8; k++)     data_q[k] <= BLANK;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            loop_q   <= loop_d;
            offset_q <= offset_d;
            tick_q   <= tick_d;
            done_q   <= done_d;
            for (int i = 0; i < DEPTH; i++) msg_q[i] <= msg_d[i];
            for (int k = 0; k < 8; k++)     data_q[k] <= data_d[k];
        end
    end

    assign data7     = data_q[7];
    assign data6     = data_q[6];
    assign data5     = data_q[5];
    assign data4     = data_q[4];
    assign data3     = data_q[3];
    assign data2     = data_q[2];
    assign data1     = data_q[1];
    assign data0     = data_q[0];
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_display_text_scroller.sv
// Directed bench for display_text_scroller: expected display frames are queued
// when a run is started and popped at each checkpoint.
module tb_display_text_scroller;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic [4:0] msg_len;
    logic       mode;
    logic       loop;
    logic       start;
    logic       stop;
    logic [7:0] data7, data6, data5, data4, data3, data2, data1, data0;
    logic       busy;
    logic       done;
    logic [1:0] state_dbg;

    logic [63:0] exp_q[$];
    logic [7:0]  mbuf[16];
    int          tests = 0;
    int          fails = 0;
    int          n;
    int          pulses;

    localparam logic [63:0] ALL_BLANK = 64'hFFFF_FFFF_FFFF_FFFF;

    display_text_scroller #(.DEPTH(16), .TICK_CYCLES(4), .BLANK(8'hFF)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .msg_len(msg_len), .mode(mode), .loop(loop), .start(start), .stop(stop),
        .data7(data7), .data6(data6), .data5(data5), .data4(data4),
        .data3(data3), .data2(data2), .data1(data1), .data0(data0),
        .busy(busy), .done(done), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    wire [63:0] disp = {data7, data6, data5, data4, data3, data2, data1, data0};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic expect_frame(input logic [63:0] f);
        exp_q.push_back(f);
    endtask

    task automatic check_frame(input string tag);
        if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL %s observed=%h expected=<empty queue>", tag, disp);
        end else begin
            check(tag, disp, exp_q.pop_front());
        end
    endtask

    function automatic logic [63:0] frame_static(input int len);
        logic [63:0] r = ALL_BLANK;
        for (int i = 0; i < 8; i++) if (i < len) r[63-8*i -: 8] = mbuf[i];
        return r;
    endfunction

    function automatic logic [63:0] frame_scroll(input int len, input int off);
        logic [63:0] r = ALL_BLANK;
        for (int k = 0; k < 8; k++) begin
            if (off + k >= 8 && off + k < len + 8) r[63-8*k -: 8] = mbuf[off+k-8];
        end
        return r;
    endfunction

    task automatic step(input int cycles);
        repeat (cycles) @(negedge clk);
    endtask

    task automatic write_buf(input logic [3:0] a, input logic [7:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic start_run(input logic [4:0] len, input logic m, input logic lp);
        msg_len = len; mode = m; loop = lp; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic stop_pulse();
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
    endtask

    // Edges until done is seen (always advances at least one edge).
    task automatic wait_done(output int cycles, input int limit);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!done && cycles < limit);
    endtask

    task automatic count_done(output int cnt, input int cycles);
        cnt = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (done) cnt++;
        end
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        msg_len = '0; mode = 1'b0; loop = 1'b0; start = 1'b0; stop = 1'b0;
        for (int i = 0; i < 16; i++) mbuf[i] = 8'hFF;
        step(2);
        expect_frame(ALL_BLANK);
        check_frame("reset_frame");
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        rst = 1'b0;
        step(1);

        // HELLO, static
        write_buf(4'd0, 8'h12); write_buf(4'd1, 8'h0e); write_buf(4'd2, 8'h16);
        write_buf(4'd3, 8'h16); write_buf(4'd4, 8'h19);
        mbuf[0] = 8'h12; mbuf[1] = 8'h0e; mbuf[2] = 8'h16; mbuf[3] = 8'h16; mbuf[4] = 8'h19;
        start_run(5'd5, 1'b0, 1'b0);
        expect_frame(64'h120e_1616_19FF_FFFF);
        expect_frame(64'h120e_1616_19FF_FFFF);
        check_frame("static_hello");
        check("static_busy", 64'(busy), 64'd1);
        step(20);
        check_frame("static_hold");
        stop_pulse();
        expect_frame(ALL_BLANK);
        check_frame("stop_idle_frame");
        check("stop_idle_busy", 64'(busy), 64'd0);

        // HELLO, single scroll pass
        start_run(5'd5, 1'b1, 1'b0);
        expect_frame(ALL_BLANK);
        expect_frame(ALL_BLANK);
        expect_frame(64'hFFFF_FFFF_FFFF_FF12);
        expect_frame(64'hFFFF_FF12_0e16_1619);
        expect_frame(ALL_BLANK);
        check_frame("scroll_t0");
        step(3);
        check_frame("scroll_before_t1");
        step(1);
        check_frame("scroll_t1");
        step(16);
        check_frame("scroll_t5");
        step(32);
        check_frame("scroll_t13");
        wait_done(n, 200);
        check("scroll_done_time", 64'(52 + n), 64'd56);
        check("scroll_busy_after_done", 64'(busy), 64'd0);
        count_done(pulses, 60);
        check("scroll_done_once", 64'(pulses), 64'd0);

        // Looping scroll, then abort
        start_run(5'd5, 1'b1, 1'b1);
        wait_done(n, 200);
        check("loop_done1_time", 64'(n), 64'd56);
        check("loop_busy_held", 64'(busy), 64'd1);
        expect_frame(ALL_BLANK);
        check_frame("loop_wrap_blank");
        wait_done(n, 200);
        check("loop_done2_time", 64'(n), 64'd56);
        step(4);
        expect_frame(frame_scroll(5, 1));
        check_frame("loop_second_pass_t1");
        stop_pulse();
        count_done(pulses, 80);
        check("loop_stop_no_done", 64'(pulses), 64'd0);
        check("loop_stop_busy", 64'(busy), 64'd0);

        // Write while busy is ignored; start+stop together ends idle
        start_run(5'd5, 1'b0, 1'b0);
        write_buf(4'd0, 8'h05);
        stop_pulse();
        start_run(5'd5, 1'b0, 1'b0);
        expect_frame(frame_static(5));
        check_frame("write_while_busy_ignored");
        msg_len = 5'd5; mode = 1'b1; start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        expect_frame(ALL_BLANK);
        check_frame("start_stop_frame");
        check("start_stop_busy", 64'(busy), 64'd0);

        // Full buffer, msg_len clamped to DEPTH
        for (int i = 0; i < 16; i++) begin
            mbuf[i] = (i < 15) ? 8'(i) : 8'h10;
            write_buf(4'(i), mbuf[i]);
        end
        start_run(5'd20, 1'b0, 1'b0);
        expect_frame(64'h0001_0203_0405_0607);
        check_frame("clamp_static");
        start_run(5'd20, 1'b1, 1'b0);
        step(48);
        expect_frame(64'h0405_0607_0809_0a0b);
        check_frame("clamp_scroll_t12");
        wait_done(n, 300);
        check("clamp_done_time", 64'(48 + n), 64'd100);

        // Asynchronous reset mid-scroll
        start_run(5'd5, 1'b1, 1'b0);
        step(30);
        #2 rst = 1'b1;
        #1;
        expect_frame(ALL_BLANK);
        check_frame("async_reset_frame");
        check("async_reset_busy", 64'(busy), 64'd0);
        check("async_reset_done", 64'(done), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) mbuf[i] = 8'hFF;
        step(1);
        start_run(5'd16, 1'b0, 1'b0);
        expect_frame(frame_static(16));
        check_frame("reset_buf_blank_lo");
        start_run(5'd16, 1'b1, 1'b0);
        step(64);
        expect_frame(frame_scroll(16, 16));
        check_frame("reset_buf_blank_hi");
        check("reset_buf_busy", 64'(busy), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/display_text_scroller.md
Name: display_text_scroller

Overview:
- Producer side of the 8-digit seven-segment display path: it generates the eight per-digit character codes (data7..data0) that the tube scanner renders.
- Holds a message buffer of up to DEPTH character codes, written by the game/menu control logic.
- Shows the message either statically (left-aligned) or scrolling right-to-left at a fixed tick rate.
- Digit 7 is the leftmost digit and digit 0 the rightmost; codes use the display's character set (0x00-0x0e hex digits, 0x10-0x24 letters f..z, BLANK renders all segments off).

Parameters:
- DEPTH, 16, message buffer entries (power of two; addresses are 4 bits at the default).
- TICK_CYCLES, 50_000_000, clk cycles per scroll step (0.5 s at 100 MHz); must be >= 1.
- BLANK, 8'hFF, code driven to unused or empty digits (decodes to all segments off).

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- wr_en  in  1  buffer write strobe
- wr_addr  in  4  buffer write index
- wr_data  in  8  character code to write
- msg_len  in  5  message length, sampled on start
- mode  in  1  0 = static, 1 = scroll; sampled on start
- loop  in  1  1 = repeat scrolling; sampled on start
- start  in  1  single-cycle start pulse
- stop  in  1  single-cycle abort pulse
- data7..data0  out  8 each  digit codes, registered
- busy  out  1  high in STATIC or SCROLL
- done  out  1  single-cycle pulse at the end of each scroll pass

Behaviour:
- Reset (async): every buffer entry = BLANK; state = IDLE; all data outputs = BLANK; busy = 0; done = 0; offset = 0; tick counter = 0.
- Buffer writes:
  - Accepted only in IDLE: at the clk edge with wr_en = 1, buf[wr_addr] <= wr_data.
  - Writes while busy are ignored.
- start handling:
  - On start, latch len = min(msg_len, DEPTH), mode and loop; clear the tick counter; set offset = 0.
  - start while busy restarts with the newly latched values.
- stop handling:
  - stop in any state returns to IDLE with all outputs BLANK and no done pulse.
  - stop and start in the same cycle: stop wins.
- States:
  - IDLE: outputs BLANK; busy = 0. start with mode = 0 goes to STATIC; start with mode = 1 goes to SCROLL.
  - STATIC: data(7-i) = buf[i] for i < len, otherwise BLANK (i = 0..7). Characters beyond index 7 are not shown. Remains in STATIC until stop or start.
  - SCROLL:
    - Virtual stream S has length len+8: S[j] = BLANK for j < 8; S[j] = buf[j-8] for 8 <= j < len+8; any index outside that range reads BLANK.
    - Window: data7 = S[offset], data6 = S[offset+1], ..., data0 = S[offset+7].
    - The tick counter counts 0..TICK_CYCLES-1; a tick occurs when it wraps.
    - On a tick with offset < len+8: offset increments by 1.
    - On a tick with offset == len+8: done = 1 for that one cycle; if loop = 1, offset returns to 0 and SCROLL continues; otherwise the block goes to IDLE.
    - The first pass begins all blank, the message enters at the right, and the pass ends all blank.
    - Start-to-done time = (len+9)*TICK_CYCLES cycles.
- len = 0: STATIC shows all BLANK; SCROLL produces 9 all-blank steps and then done.
- msg_len > DEPTH is clamped to DEPTH.
- Timing: outputs are registered from the next state, so display content is valid on the cycle after start or a tick. busy rises the cycle after start and falls the cycle after stop or the final done.

Test Plan:
- Reset mid-scroll (TICK_CYCLES = 4) -> within the same cycle: data* = 8'hFF, busy = 0, done = 0; all buffer entries read back as BLANK in a subsequent static run.
- Write "HELLO" (0x12, 0x0e, 0x16, 0x16, 0x19) at addresses 0-4, then start with mode = 0, msg_len = 5 -> data7..data3 = 12, 0e, 16, 16, 19 and data2..data0 = FF, held indefinitely.
- Same buffer, mode = 1, loop = 0, TICK_CYCLES = 4:
  - After 1 tick: data0 = 0x12, all other digits FF.
  - After 5 ticks: data4..data0 = HELLO.
  - After 13 ticks: all digits FF.
  - done pulses exactly once, 56 cycles after start; busy then drops.
- loop = 1 -> done pulses every 56 cycles; offset wraps to 0 (all blank); busy stays high; a stop pulse returns the block to IDLE with no done pulse.
- With busy = 1, pulse wr_en to addr 0 with data 0x05 -> ignored (a later static run still shows 0x12). Assert start and stop in the same cycle -> the block goes to IDLE.
- msg_len = 20, mode = 0, with buffer entries 0-15 = 0x00..0x0e, 0x10 -> static shows 00..07; in scroll mode done arrives at (16+9)*4 = 100 cycles.
